// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//
// Sprite-memory DMA engine placed between the 6502 core's bus outputs and the
// system memory bus. While idle it is a transparent passthrough of the CPU
// bus. A CPU write to $4014 latches the written byte as a source page, halts
// the CPU by gating its cycle enable, and copies 256 bytes from $XX00-$XXFF
// into the PPU OAM data port at $2004, one read/write pair per byte.
//
// Build option:
//   OAM_DMA_ODD_ALIGN_EN  when defined, one extra dummy cycle (ODD) is
//                         inserted if the alignment cycle sees parity=1,
//                         matching real console timing (513 or 514 cycles).
//                         When undefined every transfer is 513 cycles.
//
// Ports:
//   clk       system clock, shared with the CPU
//   reset     asynchronous active-high reset
//   ce        CPU cycle enable; all state advances only when ce=1
//   cpu_aout  CPU address            cpu_dout  CPU write data
//   cpu_mr    CPU read strobe        cpu_mw    CPU write strobe
//   mem_din   read data returned by the memory bus
//   cpu_ce    gated enable to the CPU (ce & ~busy)
//   bus_aout  address to memory bus  bus_dout  write data to memory bus
//   bus_mr    read strobe to bus     bus_mw    write strobe to bus
//   busy      high whenever a transfer is in progress
// ---------------------------------------------------------------------------
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mr,
  input  logic        cpu_mw,
  input  logic [7:0]  mem_din,
  output logic        cpu_ce,
  output logic [15:0] bus_aout,
  output logic [7:0]  bus_dout,
  output logic        bus_mr,
  output logic        bus_mw,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ODD   = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dmaState_t;

  localparam logic [15:0] DmaTriggerAddr = 16'h4014;
  localparam logic [15:0] OamDataAddr    = 16'h2004;

  dmaState_t state;
  dmaState_t nextState;

  logic [7:0] page;
  logic [7:0] addr;
  logic [7:0] data;
  logic       parity;

  logic       trigger;
  logic       lastByte;
  logic       oddAlignEn;

  // Compile-time switch for the odd-cycle alignment behaviour. Keeping it as
  // a constant signal lets the next-state logic stay identical in both builds.
`ifdef OAM_DMA_ODD_ALIGN_EN
  assign oddAlignEn = 1'b1;
`else
  assign oddAlignEn = 1'b0;
`endif

  // A $4014 write is only recognised while idle; once busy the CPU is halted
  // and its strobes never reach the bus, so it cannot retrigger.
  assign trigger  = ce & cpu_mw & (cpu_aout == DmaTriggerAddr) & (state == IDLE);
  assign lastByte = (addr == 8'hFF);

  // State register. Reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (ce) begin
      state <= nextState;
    end
  end

  // Next-state logic. The machine only moves on ce=1 cycles (enforced by the
  // state register), so this block just describes the sequence.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (trigger) begin
          nextState = ALIGN;
        end
      end
      ALIGN: begin
        if (oddAlignEn && parity) begin
          nextState = ODD;
        end else begin
          nextState = READ;
        end
      end
      ODD: begin
        nextState = READ;
      end
      READ: begin
        nextState = WRITE;
      end
      WRITE: begin
        if (lastByte) begin
          nextState = IDLE;
        end else begin
          nextState = READ;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Transfer datapath: source page, byte index, the byte in flight, and the
  // free-running cycle parity used to decide on the extra alignment cycle.
  // The byte index is cleared on trigger so every copy starts at $XX00 even
  // if a previous transfer was cut short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page   <= 8'h00;
      addr   <= 8'h00;
      data   <= 8'h00;
      parity <= 1'b0;
    end else if (ce) begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (trigger) begin
            page <= cpu_dout;
            addr <= 8'h00;
          end
        end
        READ: begin
          data <= mem_din;
        end
        WRITE: begin
          addr <= addr + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Bus outputs. These are combinational from the registered state and the
  // live CPU inputs so that passthrough adds no latency. Outside IDLE the
  // CPU strobes are forced off; the dummy cycles leave the CPU address on
  // the bus with no strobe asserted.
  always_comb begin
    bus_aout = cpu_aout;
    bus_dout = cpu_dout;
    bus_mr   = cpu_mr;
    bus_mw   = cpu_mw;
    busy     = (state != IDLE);
    cpu_ce   = ce & (state == IDLE);
    case (state)
      ALIGN, ODD: begin
        bus_mr = 1'b0;
        bus_mw = 1'b0;
      end
      READ: begin
        bus_aout = {page, addr};
        bus_mr   = 1'b1;
        bus_mw   = 1'b0;
      end
      WRITE: begin
        bus_aout = OamDataAddr;
        bus_dout = data;
        bus_mr   = 1'b0;
        bus_mw   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
//
// Self-checking bench for oam_dma. A byte-array memory answers bus reads.
// Each DMA is predicted as a queue of bus operations built from the
// transfer rules (dummy alignment cycle(s), then READ/WRITE pairs for
// bytes $00..$FF), and compared cycle by cycle on every ce=1 cycle.
// ---------------------------------------------------------------------------
module tb_oam_dma;

  logic        clk;
  logic        reset;
  logic        ce;
  logic [15:0] cpu_aout;
  logic [7:0]  cpu_dout;
  logic        cpu_mr;
  logic        cpu_mw;
  logic [7:0]  mem_din;
  logic        cpu_ce;
  logic [15:0] bus_aout;
  logic [7:0]  bus_dout;
  logic        bus_mr;
  logic        bus_mw;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int ceCount;

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam bit OddEn = 1'b1;
`else
  localparam bit OddEn = 1'b0;
`endif

  typedef struct packed {
    logic        dummy;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } busOp_t;

  logic [7:0] mem [0:65535];

  assign mem_din = mem[bus_aout];

  oam_dma dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .cpu_aout (cpu_aout),
    .cpu_dout (cpu_dout),
    .cpu_mr   (cpu_mr),
    .cpu_mw   (cpu_mw),
    .mem_din  (mem_din),
    .cpu_ce   (cpu_ce),
    .bus_aout (bus_aout),
    .bus_dout (bus_dout),
    .bus_mr   (bus_mr),
    .bus_mw   (bus_mw),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of ce cycles since reset; its LSB is the expected parity.
  always @(posedge clk or posedge reset) begin
    if (reset) ceCount <= 0;
    else if (ce) ceCount <= ceCount + 1;
  end

  task automatic driveIdle();
    cpu_mr   = 1'b0;
    cpu_mw   = 1'b0;
    cpu_aout = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
    cpu_dout = 8'($urandom);
  endtask

  // Leaves the bench just after a posedge with ce=0 so the next cycle is
  // the trigger cycle; the alignment cycle then sees parity alignParity.
  task automatic alignTo(input int alignParity);
    bit reached;
    reached = 1'b0;
    ce = 1'b1;
    driveIdle();
    for (int k = 0; k < 4 && !reached; k++) begin
      @(posedge clk); #1;
      if ((ceCount % 2) != alignParity) begin
        reached = 1'b1;
        ce = 1'b0;
      end
    end
  endtask

  task automatic runDma(input logic [7:0] pg, input bit gate, input bit isolate,
                        input int abortAfter, output int busyCe);
    busOp_t      expQ[$];
    busOp_t      e;
    bit          alignOdd;
    bit          done;
    int          writes;
    int          stray;
    int          expLen;
    logic [26:0] act;
    logic [26:0] expv;

    @(posedge clk); #1;
    ce = 1'b1; cpu_mr = 1'b0; cpu_mw = 1'b1; cpu_aout = 16'h4014; cpu_dout = pg;
    alignOdd = (((ceCount + 1) % 2) == 1);

    e = '0; e.dummy = 1'b1; expQ.push_back(e);
    if (OddEn && alignOdd) expQ.push_back(e);
    for (int i = 0; i < 256; i++) begin
      e = '0; e.rd = 1'b1; e.a = {pg, i[7:0]}; expQ.push_back(e);
      e = '0; e.wr = 1'b1; e.a = 16'h2004; e.d = mem[{pg, i[7:0]}]; expQ.push_back(e);
    end
    expLen = expQ.size();

    @(negedge clk);
    checks++;
    if ({busy, cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout} !== {1'b0, 1'b1, 1'b0, 1'b1, 16'h4014, pg}) begin
      failures++;
      $display("[TB] FAIL trigger_passthrough actual=%h expected=%h",
               {busy, cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout}, {1'b0, 1'b1, 1'b0, 1'b1, 16'h4014, pg});
    end

    done = 1'b0; busyCe = 0; writes = 0; stray = 0;
    for (int cyc = 1; cyc <= 4000 && !done; cyc++) begin
      @(posedge clk); #1;
      ce = gate ? ((cyc % 3) == 0) : 1'b1;
      if (isolate && expQ.size() > 0) begin
        cpu_mw = 1'b1; cpu_mr = 1'($urandom); cpu_aout = 16'h4014; cpu_dout = 8'($urandom);
      end else begin
        driveIdle();
      end
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        checks++;
        if ({cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout} !== {ce, cpu_mr, cpu_mw, cpu_aout, cpu_dout}) begin
          failures++;
          $display("[TB] FAIL release_passthrough actual=%h expected=%h",
                   {cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout}, {ce, cpu_mr, cpu_mw, cpu_aout, cpu_dout});
        end
      end else if (expQ.size() == 0) begin
        done = 1'b1;
        checks++; failures++;
        $display("[TB] FAIL busy_overrun actual=busy expected=idle after %0d ce cycles", busyCe);
      end else if (ce) begin
        e = expQ.pop_front();
        busyCe++;
        if (e.dummy) e.a = cpu_aout;
        if (bus_mw) begin
          if (bus_aout == 16'h2004) writes++;
          else stray++;
        end
        act  = {cpu_ce, bus_mr, bus_mw, bus_aout, e.wr ? bus_dout : 8'h00};
        expv = {1'b0, e.rd, e.wr, e.a, e.wr ? e.d : 8'h00};
        checks++;
        if (act !== expv) begin
          failures++;
          $display("[TB] FAIL dma_cycle%0d actual=%h expected=%h", busyCe, act, expv);
        end
        if (abortAfter > 0 && writes == abortAfter) begin
          #2;
          cpu_mr = 1'b1; cpu_mw = 1'b0; cpu_aout = 16'h8123; cpu_dout = 8'h77;
          reset = 1'b1;
          #1;
          checks++;
          if ({busy, cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout} !== {1'b0, ce, 1'b1, 1'b0, 16'h8123, 8'h77}) begin
            failures++;
            $display("[TB] FAIL abort_passthrough actual=%h expected=%h",
                     {busy, cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout}, {1'b0, ce, 1'b1, 1'b0, 16'h8123, 8'h77});
          end
          @(posedge clk); #1;
          reset = 1'b0;
          driveIdle();
          return;
        end
      end else begin
        e = expQ[0];
        checks++;
        if ({cpu_ce, bus_mr, bus_mw} !== {1'b0, e.rd, e.wr}) begin
          failures++;
          $display("[TB] FAIL hold_strobes actual=%b expected=%b", {cpu_ce, bus_mr, bus_mw}, {1'b0, e.rd, e.wr});
        end
      end
    end

    if (!done) begin
      checks++; failures++;
      $display("[TB] FAIL dma_timeout actual=busy expected=idle within 4000 clocks");
    end
    checks++;
    if (busyCe != expLen) begin
      failures++;
      $display("[TB] FAIL busy_length actual=%0d expected=%0d", busyCe, expLen);
    end
    checks++;
    if (writes != 256 || stray != 0) begin
      failures++;
      $display("[TB] FAIL write_count actual=%0d/%0d expected=256/0", writes, stray);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      ce = 1'(i); cpu_mr = 1'($urandom); cpu_mw = 1'($urandom);
      cpu_aout = 16'($urandom); cpu_dout = 8'($urandom);
      #3;
      checks++;
      if ({busy, cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout} !== {1'b0, ce, cpu_mr, cpu_mw, cpu_aout, cpu_dout}) begin
        failures++;
        $display("[TB] FAIL reset_state actual=%h expected=%h",
                 {busy, cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout}, {1'b0, ce, cpu_mr, cpu_mw, cpu_aout, cpu_dout});
      end
    end
    @(posedge clk); #1;
    ce = 1'b0; driveIdle();
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [15:0] a;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      ce = 1'($urandom); cpu_aout = a; cpu_dout = 8'($urandom);
      cpu_mr = 1'($urandom); cpu_mw = 1'($urandom);
      if (i == 8) begin ce = 1'b1; cpu_aout = 16'h8000; cpu_mr = 1'b1; cpu_mw = 1'b0; end
      if (i == 9) begin ce = 1'b1; cpu_aout = 16'h0300; cpu_dout = 8'h5A; cpu_mr = 1'b0; cpu_mw = 1'b1; end
      @(negedge clk);
      checks++;
      if ({busy, cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout} !== {1'b0, ce, cpu_mr, cpu_mw, cpu_aout, cpu_dout}) begin
        failures++;
        $display("[TB] FAIL passthrough%0d actual=%h expected=%h", i,
                 {busy, cpu_ce, bus_mr, bus_mw, bus_aout, bus_dout}, {1'b0, ce, cpu_mr, cpu_mw, cpu_aout, cpu_dout});
      end
    end
    @(posedge clk); #1;
    driveIdle();
  endtask

  task automatic test_dma_basic();
    int n;
    for (int i = 0; i < 256; i++) mem[{8'h02, i[7:0]}] = i[7:0] ^ 8'hA5;
    alignTo(0);
    runDma(8'h02, 1'b0, 1'b0, 0, n);
    checks++;
    if (n != 513) begin
      failures++;
      $display("[TB] FAIL basic_length actual=%0d expected=513", n);
    end
  endtask

  task automatic test_cycle_count();
    int n;
    for (int i = 0; i < 256; i++) mem[{8'h11, i[7:0]}] = 8'($urandom);
    alignTo(1);
    runDma(8'h11, 1'b0, 1'b0, 0, n);
    checks++;
    if (n != (OddEn ? 514 : 513)) begin
      failures++;
      $display("[TB] FAIL odd_align_length actual=%0d expected=%0d", n, OddEn ? 514 : 513);
    end
  endtask

  task automatic test_ce_gating();
    int n;
    alignTo(0);
    runDma(8'h02, 1'b1, 1'b0, 0, n);
  endtask

  task automatic test_cpu_isolation();
    int n;
    for (int i = 0; i < 256; i++) mem[{8'h7E, i[7:0]}] = 8'($urandom);
    alignTo(1);
    runDma(8'h7E, 1'b0, 1'b1, 0, n);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ce = 1'b1; driveIdle();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL no_retrigger actual=%b expected=0", busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 256; i++) mem[{8'h03, i[7:0]}] = 8'($urandom);
    alignTo(0);
    runDma(8'h02, 1'b0, 1'b0, 100, n);
    alignTo(0);
    runDma(8'h03, 1'b0, 1'b0, 0, n);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0;
    cpu_aout = 16'h0000; cpu_dout = 8'h00; cpu_mr = 1'b0; cpu_mw = 1'b0;
    test_reset();
    test_passthrough();
    test_dma_basic();
    test_cycle_count();
    test_ce_gating();
    test_cpu_isolation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-memory DMA engine sitting directly between the 6502 core's bus outputs (aout/dout/mr/mw) and the system memory bus. It watches CPU writes to $4014 and, once one is seen, halts the core by gating its clock-enable. It then owns the bus and copies 256 bytes from CPU page $XX00–$XXFF to the PPU OAM data port $2004, one read/write pair per byte. When idle it is a transparent passthrough of the CPU bus.

## Interface
- No parameters.
- clk  in  1  system clock, shared with the CPU.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  CPU cycle enable from the clock divider; all state advances only when ce=1.
- cpu_aout  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_mr  in  1  CPU read strobe.
- cpu_mw  in  1  CPU write strobe.
- mem_din  in  8  read data returned by the memory bus (also fed to CPU DIN externally).
- cpu_ce  out  1  gated enable to the CPU: ce & ~busy.
- bus_aout  out  16  address to memory bus.
- bus_dout  out  8  write data to memory bus.
- bus_mr  out  1  read strobe to memory bus.
- bus_mw  out  1  write strobe to memory bus.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Registers: state, page[7:0], addr[7:0], data[7:0], parity (toggles on every ce=1 cycle).
- Trigger: in IDLE, on a ce=1 cycle with cpu_mw=1 and cpu_aout=16'h4014, latch page←cpu_dout and go to ALIGN. The $4014 write itself passes through to the bus unchanged.
- States and transitions (each transition on ce=1 only):
  - IDLE: passthrough. bus_* = cpu_*. busy=0.
  - ALIGN: dummy cycle. bus_mr=0, bus_mw=0, bus_aout=cpu_aout. Next state is ODD if the feature is enabled and parity=1; otherwise READ.
  - ODD: one extra dummy cycle, same outputs as ALIGN. Next state is READ.
  - READ: bus_aout={page,addr}, bus_mr=1, bus_mw=0. Latch data←mem_din. Next state is WRITE.
  - WRITE: bus_aout=16'h2004, bus_dout=data, bus_mw=1, bus_mr=0. addr←addr+1, wrapping 8 bits. Next state is IDLE if addr was 8'hFF, else READ.
- In every non-IDLE state, CPU strobes are ignored and never reach the bus.
- A new $4014 write while busy cannot occur, because the CPU is halted. No queuing is provided.
- ce=0: all registers hold and outputs stay stable.

## Timing
- Reset values: state=IDLE, page=0, addr=0, data=0, parity=0.
- Outputs under reset: busy=0, cpu_ce=ce, bus_* = cpu_* passthrough.
- Trigger edge: state is registered, so busy and cpu_ce=0 appear starting the ce cycle after the $4014 write.
- Duration: 1 ALIGN cycle (+1 ODD cycle) + 512 READ/WRITE cycles, i.e. 513 or 514 ce cycles with busy=1.
- cpu_ce returns to ce on the first ce cycle after the final WRITE to addr $FF.
- Reset mid-transfer: immediate abort to IDLE. The CPU bus is passed through and there is no partial-completion flag.
- cpu_ce, bus_* and busy are combinational from the registered state and the CPU inputs. The block adds no extra latency in passthrough.

## Configuration
- OAM_DMA_ODD_ALIGN_EN defined: an extra ODD dummy cycle is inserted when ALIGN is entered with parity=1. This gives 513 cycles when starting on an even cycle and 514 on an odd one, matching hardware timing.
- Undefined: the ODD state is never entered and every transfer takes exactly 513 ce cycles.
- The parity register exists in both builds. Without the macro it is unused.

## Test plan
- Passthrough: CPU read $8000 and write $0300←$5A with no DMA. bus_* equal cpu_* every cycle, busy=0, cpu_ce=ce.
- Basic DMA: preload $0200–$02FF with i^8'hA5, then CPU writes $4014←$02. Expected sequence: READ $0200, WRITE $2004←$A5, …, READ $02FF, WRITE $2004←$5A. Exactly 256 writes to $2004 and none elsewhere.
- Cycle count: trigger on an even parity cycle gives busy=1 for 513 ce cycles. With OAM_DMA_ODD_ALIGN_EN, an odd-parity trigger gives 514; without the macro it gives 513.
- ce gating: hold ce=1 only every 3rd clk during the DMA. Byte order and values are unchanged, the ce-cycle count is unchanged, and no strobe changes while ce=0.
- CPU isolation: the CPU drives cpu_mw=1 with cpu_aout=$4014 during busy. The bus shows only DMA traffic and no retrigger occurs.
- Reset mid-transfer: assert reset after 100 bytes. busy→0 asynchronously and the bus returns to passthrough. A following $4014←$03 runs a full fresh 256-byte copy starting at $0300.
